// File: rtl/cache_data_array.sv
// -----------------------------------------------------------------------------
// cache_data_array
//   N-way cache line data store. A single CPU request port (read or
//   byte-masked write) and a multi-beat refill engine share one write port.
//   Reads are synchronous: the line is registered one cycle after acceptance.
//
// Ports
//   CK, RST                   clock, asynchronous active-high reset
//   req_valid/req_ready       CPU request handshake
//   req_we, req_way,
//   req_index, req_bmask,
//   req_wdata                 request attributes (bmask bit i -> byte i)
//   rsp_valid, rsp_rdata      read response (rdata holds when rsp_valid=0)
//   fill_start, fill_way,
//   fill_index                refill command, sampled only in IDLE
//   fill_valid/fill_ready,
//   fill_data                 refill beat handshake, beat 0 = low bits
//   fill_busy, fill_done      refill in progress / one-cycle completion pulse
//
// Handshake rule: a transfer happens on a rising CK edge where both valid
// and ready are high; valid may be raised without waiting for ready, and
// ready never depends on a transfer completing in the same cycle.
// -----------------------------------------------------------------------------
module cache_data_array #(
  parameter int NUM_WAYS = 2,
  parameter int INDEX_W  = 5,
  parameter int LINE_W   = 128,
  parameter int BEAT_W   = 32,
  localparam int WAY_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  localparam int NBYTES  = LINE_W / 8,
  localparam int BEATS   = LINE_W / BEAT_W
) (
  input  logic               CK,
  input  logic               RST,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [WAY_W-1:0]   req_way,
  input  logic [INDEX_W-1:0] req_index,
  input  logic [NBYTES-1:0]  req_bmask,
  input  logic [LINE_W-1:0]  req_wdata,
  output logic               rsp_valid,
  output logic [LINE_W-1:0]  rsp_rdata,
  input  logic               fill_start,
  input  logic [WAY_W-1:0]   fill_way,
  input  logic [INDEX_W-1:0] fill_index,
  input  logic               fill_valid,
  output logic               fill_ready,
  input  logic [BEAT_W-1:0]  fill_data,
  output logic               fill_busy,
  output logic               fill_done
);

  localparam int DEPTH = 1 << INDEX_W;
  localparam int WORDS = NUM_WAYS * DEPTH;
  localparam int AW    = WAY_W + INDEX_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BPB   = BEAT_W / 8;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WAY_W-1:0]     r_way;
  logic [INDEX_W-1:0]   r_index;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_done;
  logic                 r_rvalid;
  logic [LINE_W-1:0]    r_rdata;
  logic [LINE_W-1:0]    r_mem [WORDS];

  logic                 w_req_way_ok;
  logic                 w_fill_way_ok;
  logic                 w_req_fire;
  logic                 w_rd_fire;
  logic                 w_cpu_wr;
  logic                 w_beat_fire;
  logic                 w_last_beat;
  logic                 w_wr_en;
  logic [AW-1:0]        w_wr_addr;
  logic [LINE_W-1:0]    w_wr_data;
  logic [NBYTES-1:0]    w_wr_bmask;
  logic [AW-1:0]        w_rd_addr;

  // Way range check only matters when NUM_WAYS does not fill the way field.
  generate
    if ((1 << WAY_W) == NUM_WAYS) begin : g_way_pow2
      assign w_req_way_ok  = 1'b1;
      assign w_fill_way_ok = 1'b1;
    end else begin : g_way_npow2
      localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(NUM_WAYS - 1);
      assign w_req_way_ok  = (req_way <= LAST_WAY);
      assign w_fill_way_ok = (r_way   <= LAST_WAY);
    end
  endgenerate

  assign w_req_fire  = req_valid && req_ready;
  assign w_rd_fire   = w_req_fire && !req_we;
  assign w_cpu_wr    = w_req_fire && req_we && w_req_way_ok;
  assign w_beat_fire = (r_state == S_FILL) && fill_valid;
  assign w_last_beat = w_beat_fire && (r_cnt == CNT_W'(BEATS - 1));
  assign w_rd_addr   = {req_way, req_index};

  assign rsp_valid = r_rvalid;
  assign rsp_rdata = r_rdata;
  assign fill_done = r_done;

  // FSM next state and handshake outputs. req_ready is gated by RST so the
  // port reads not-ready while reset is held, even though the state is IDLE.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    fill_ready  = 1'b0;
    fill_busy   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = !fill_start && !RST;
        if (fill_start) w_state_nxt = S_FILL;
      end
      S_FILL: begin
        fill_ready = 1'b1;
        fill_busy  = 1'b1;
        if (w_last_beat) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shared write port. CPU writes only happen in IDLE and beats only in
  // FILL, so the two sources never collide. A beat is expressed as a byte
  // mask over the replicated beat so one byte-masked write path serves both.
  always_comb begin
    w_wr_en    = 1'b0;
    w_wr_addr  = '0;
    w_wr_data  = '0;
    w_wr_bmask = '0;
    if (w_cpu_wr) begin
      w_wr_en    = 1'b1;
      w_wr_addr  = {req_way, req_index};
      w_wr_data  = req_wdata;
      w_wr_bmask = req_bmask;
    end else if (w_beat_fire && w_fill_way_ok) begin
      w_wr_en   = 1'b1;
      w_wr_addr = {r_way, r_index};
      w_wr_data = {BEATS{fill_data}};
      for (int b = 0; b < NBYTES; b++) begin
        w_wr_bmask[b] = ((b / BPB) == int'(r_cnt));
      end
    end
  end

  // Storage is not reset.
  always_ff @(posedge CK) begin
    if (w_wr_en) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (w_wr_bmask[b]) r_mem[w_wr_addr][8*b +: 8] <= w_wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_way    <= '0;
      r_index  <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_done   <= w_last_beat;
      r_rvalid <= w_rd_fire;
      if (w_rd_fire) begin
        r_rdata <= w_req_way_ok ? r_mem[w_rd_addr] : '0;
      end
      if ((r_state == S_IDLE) && fill_start) begin
        r_way   <= fill_way;
        r_index <= fill_index;
        r_cnt   <= '0;
      end else if (w_beat_fire) begin
        r_cnt <= w_last_beat ? '0 : r_cnt + 1'b1;
      end
    end
  end

endmodule
